ex_wb_writeback: RTL
====================

Name: ex_wb_writeback

Overview:
- EX/WB pipeline register plus writeback stage of the 3-stage RV32 core.
- Sits directly downstream of the control-field decoder and ALU. It captures the decoded control (regsel, regwrite, gpio_we), the destination register, the ALU result, the U-type immediate and the switch input at the end of EX.
- It owns the 32-entry register file (x0 hardwired to 0), the HEX GPIO output register, and WB->EX bypass on the register read ports.

Parameters:
XLEN, 32, datapath width
GPIO_RST, 32'h0, reset value of gpio_out

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush_ex  in  1  turn the EX-stage instruction into a bubble (no write, no GPIO update)
regsel_ex  in  2  writeback source select from the decoder: 00 switches, 01 imm20, 10 ALU, 11 reserved
regwrite_ex  in  1  register write enable from the decoder
gpio_we_ex  in  1  HEX GPIO write enable from the decoder
rd_ex  in  5  destination register index
alu_r_ex  in  XLEN  ALU result
imm20_ex  in  20  U-type immediate
gpio_in  in  XLEN  switch input, sampled at the EX/WB edge
rs1_addr  in  5  read port A address (EX stage)
rs2_addr  in  5  read port B address (EX stage)
rs1_data  out  XLEN  read port A data, with bypass
rs2_data  out  XLEN  read port B data, with bypass
gpio_out  out  XLEN  HEX display register
wb_data  out  XLEN  current writeback value (debug/trace)
wb_we  out  1  effective register-file write enable in WB (debug/trace)

Behaviour:
- Reset (rst=1 at an edge):
  - All EX/WB register fields are cleared: regwrite=0, gpio_we=0, regsel=00, rd=0, data fields 0.
  - All 32 registers are set to 0.
  - gpio_out is set to GPIO_RST.
  - A writeback pending in WB at that edge is discarded and does not reach the register file.
- EX/WB capture: at each non-reset edge the register loads all *_ex fields and gpio_in.
  - If flush_ex=1, it loads regwrite=0 and gpio_we=0; other fields are don't-care.
  - There is no stall input; the register captures every cycle.
- Writeback mux in the WB cycle, combinational from the EX/WB register:
  - 00 -> sampled gpio_in
  - 01 -> {imm20, 12'b0}
  - 10 -> alu_r
  - 11 -> 0, and the write is suppressed
- wb_we = regwrite & (regsel != 11) & (rd != 0).
- Register-file write: at the edge ending the WB cycle, if wb_we then regs[rd] <= wb_data.
  - Latency: EX inputs presented in cycle N are captured at edge N+1 and written to the register file at edge N+2.
- Read ports are combinational.
  - rsX_addr == 0 -> rsX_data = 0.
  - Else if wb_we and rsX_addr == WB rd -> rsX_data = wb_data (bypass, so back-to-back dependent instructions need no stall).
  - Else -> regs[rsX_addr].
- GPIO write: at edge N+1, if gpio_we_ex=1 and flush_ex=0, gpio_out <= rs1_data as seen in cycle N, including any bypass.
  - gpio_we and regwrite may both be set in the same instruction; both take effect independently.
- Writes to x0 are dropped. x0 always reads 0, even when WB targets x0.
- Port A and port B reading the same bypassed register both get wb_data.
- Reset asserted during a multi-instruction sequence: after the reset edge the state is identical to power-on reset.

Test Plan:
- Reset: drive rst=1 for one edge, then read all 32 regs -> all 0; gpio_out=0; wb_we=0.
- LUI writeback: regsel=01, imm20=20'hABCDE, rd=5, regwrite=1 in cycle N -> wb_data=32'hABCDE000 in cycle N+1. In cycle N+1, rs1_addr=5 returns 32'hABCDE000 via bypass; after edge N+2 it returns the same from the register file.
- Back-to-back bypass: ALU writes 7 to x3, then the next instruction reads x3 on both ports -> rs1_data=rs2_data=7 the cycle after capture. A write to x0 of 32'hFFFFFFFF -> x0 still reads 0 and wb_we=0.
- Switch read and HEX write: gpio_in=32'h1234 with regsel=00, rd=8 -> x8=32'h1234. Then gpio_we=1, rs1_addr=8 -> gpio_out=32'h1234 one edge later. regwrite=0 on the GPIO instruction -> no register changes.
- Flush and reserved select: flush_ex=1 with regwrite=1, gpio_we=1, rd=4 -> x4 and gpio_out unchanged. regsel=11 with regwrite=1 -> wb_we=0 and the register is unchanged.
- Reset mid-writeback: capture an ALU write of 9 to x6, then assert rst on the next edge -> x6 reads 0, gpio_out=GPIO_RST.

Source files
------------

// File: rtl/ex_wb_writeback.sv
// ex_wb_writeback: EX/WB pipeline register, register file with WB->EX bypass, and HEX GPIO register.
module ex_wb_writeback #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] GPIO_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_ex,
  input  logic [1:0]      regsel_ex,
  input  logic            regwrite_ex,
  input  logic            gpio_we_ex,
  input  logic [4:0]      rd_ex,
  input  logic [XLEN-1:0] alu_r_ex,
  input  logic [19:0]     imm20_ex,
  input  logic [XLEN-1:0] gpio_in,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] gpio_out,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_we
);
  logic [1:0]      regsel_q;
  logic            regwrite_q;
  logic            gpio_we_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_r_q;
  logic [19:0]     imm20_q;
  logic [XLEN-1:0] gpio_in_q;
  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] gpio_out_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      regsel_q   <= '0;
      regwrite_q <= 1'b0;
      gpio_we_q  <= 1'b0;
      rd_q       <= '0;
      alu_r_q    <= '0;
      imm20_q    <= '0;
      gpio_in_q  <= '0;
    end else begin
      regsel_q   <= regsel_ex;
      regwrite_q <= regwrite_ex & ~flush_ex;
      gpio_we_q  <= gpio_we_ex & ~flush_ex;
      rd_q       <= rd_ex;
      alu_r_q    <= alu_r_ex;
      imm20_q    <= imm20_ex;
      gpio_in_q  <= gpio_in;
    end
  end
  always_comb begin
    wb_data = regsel_q == 2'b00 ? gpio_in_q :
              regsel_q == 2'b01 ? {imm20_q, 12'b0} :
              regsel_q == 2'b10 ? alu_r_q : '0;
    wb_we   = regwrite_q & (regsel_q != 2'b11) & (rd_q != 5'd0);
  end
  // Reset takes priority so a writeback pending at the reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_we) begin
      regs_q[rd_q] <= wb_data;
    end
  end
  always_comb begin
    rs1_data = rs1_addr == 5'd0 ? '0 : (wb_we && rs1_addr == rd_q) ? wb_data : regs_q[rs1_addr];
    rs2_data = rs2_addr == 5'd0 ? '0 : (wb_we && rs2_addr == rd_q) ? wb_data : regs_q[rs2_addr];
  end
  // GPIO is written from the EX-stage read of rs1, so it sees bypassed data.
  always_ff @(posedge clk) begin
    if (rst) gpio_out_q <= GPIO_RST;
    else if (gpio_we_ex && !flush_ex) gpio_out_q <= rs1_data;
  end
  assign gpio_out = gpio_out_q;
endmodule
